// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives a 1-cycle-latency instruction memory,
// and predicts JAL (always taken) and conditional branches (2-bit counter BHT).
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        bp_update_valid,
    input  logic [31:0] bp_update_pc,
    input  logic        bp_update_taken,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IFID_in,
    output logic [31:0] PC_plus4_IFID_in,
    output logic [31:0] instruction_IFID_in,
    output logic        ECALL_IFID_in,
    output logic        predict_branch_taken
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [31:0] NOP_INSTR_HEX   = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR_HEX = 32'h0000_0073;
    localparam logic [6:0]  OPC_JAL         = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH      = 7'b1100011;

    logic [1:0]  r_state;
    logic [31:0] r_pc_fetch;
    logic [31:0] r_f1_pc;
    logic        r_f1_valid;
    logic [31:0] r_hold_instr;
    logic        r_hold_pred;
    logic [1:0]  r_bht      [BHT_ENTRIES];
    logic [1:0]  w_bht_next [BHT_ENTRIES];

    logic             w_run_valid;
    logic [31:0]      w_instr;
    logic             w_is_jal;
    logic             w_is_br;
    logic [IDX_W-1:0] w_lookup_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_bht_ctr;
    logic             w_pred_run;
    logic             w_pred;
    logic [31:0]      w_imm_j;
    logic [31:0]      w_imm_b;
    logic [31:0]      w_target;
    logic [31:0]      w_next_pc;
    logic             w_advance;
    logic             w_unused_bits;

    // In HOLD the presented instruction comes from the hold register so it cannot
    // drift with whatever the memory returns while no request is outstanding.
    assign w_run_valid = (r_state == ST_RUN) && r_f1_valid;
    assign w_instr     = (r_state == ST_HOLD) ? r_hold_instr :
                         (w_run_valid ? imem_rdata : NOP_INSTR_HEX);

    assign w_is_jal     = (w_instr[6:0] == OPC_JAL);
    assign w_is_br      = (w_instr[6:0] == OPC_BRANCH);
    assign w_lookup_idx = r_f1_pc[IDX_W+1:2];
    assign w_bht_ctr    = r_bht[w_lookup_idx];
    assign w_pred_run   = w_run_valid && (w_is_jal || (w_is_br && w_bht_ctr[1]));
    assign w_pred       = (r_state == ST_HOLD) ? r_hold_pred : w_pred_run;

    assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                       w_instr[30:21], 1'b0};
    assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                       w_instr[11:8], 1'b0};
    assign w_target = r_f1_pc + (w_is_jal ? w_imm_j : w_imm_b);

    // The stall-release cycle advances like a normal RUN cycle, using the held prediction.
    assign w_advance = (r_state != ST_BOOT) && !stall && !redirect_valid;
    assign w_next_pc = w_pred ? w_target : (r_pc_fetch + 32'd4);

    assign imem_en              = w_advance;
    assign imem_addr            = r_pc_fetch;
    assign PC_IFID_in           = r_f1_pc;
    assign PC_plus4_IFID_in     = r_f1_pc + 32'd4;
    assign instruction_IFID_in  = w_instr;
    assign ECALL_IFID_in        = (w_instr == ECALL_INSTR_HEX);
    assign predict_branch_taken = w_pred;

    assign w_upd_idx     = bp_update_pc[IDX_W+1:2];
    assign w_unused_bits = ^{bp_update_pc[31:IDX_W+2], bp_update_pc[1:0], redirect_pc[1:0]};

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic w_hit;
            assign w_hit = bp_update_valid && (w_upd_idx == IDX_W'(gi));
            assign w_bht_next[gi] =
                (w_hit && bp_update_taken && (r_bht[gi] != 2'b11))  ? r_bht[gi] + 2'd1 :
                (w_hit && !bp_update_taken && (r_bht[gi] != 2'b00)) ? r_bht[gi] - 2'd1 :
                r_bht[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else begin
            r_bht <= w_bht_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc_fetch   <= RESET_PC;
            r_f1_pc      <= 32'd0;
            r_f1_valid   <= 1'b0;
            r_hold_instr <= NOP_INSTR_HEX;
            r_hold_pred  <= 1'b0;
        end else if (redirect_valid) begin
            r_pc_fetch <= {redirect_pc[31:2], 2'b00};
            r_f1_valid <= 1'b0;
            r_state    <= ST_RUN;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (stall) begin
                        r_state      <= ST_HOLD;
                        r_hold_instr <= w_instr;
                        r_hold_pred  <= w_pred;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
            // A taken prediction squashes the sequential request already in flight.
            if (w_advance) begin
                r_f1_pc    <= r_pc_fetch;
                r_f1_valid <= !w_pred;
                r_pc_fetch <= w_next_pc;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: expected presented-instruction stream goes into a
// queue, a negedge monitor pops and compares; stall/redirect/reset details are checked inline.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] JAL40 = 32'h0400_006F;
    localparam logic [31:0] BEQ80 = 32'h0800_0063;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        bp_update_valid;
    logic [31:0] bp_update_pc;
    logic        bp_update_taken;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] PC_IFID_in;
    logic [31:0] PC_plus4_IFID_in;
    logic [31:0] instruction_IFID_in;
    logic        ECALL_IFID_in;
    logic        predict_branch_taken;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    if_fetch_unit #(
        .RESET_PC    (32'h0000_0100),
        .BHT_ENTRIES (64)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall                (stall),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .bp_update_valid      (bp_update_valid),
        .bp_update_pc         (bp_update_pc),
        .bp_update_taken      (bp_update_taken),
        .imem_en              (imem_en),
        .imem_addr            (imem_addr),
        .imem_rdata           (imem_rdata),
        .PC_IFID_in           (PC_IFID_in),
        .PC_plus4_IFID_in     (PC_plus4_IFID_in),
        .instruction_IFID_in  (instruction_IFID_in),
        .ECALL_IFID_in        (ECALL_IFID_in),
        .predict_branch_taken (predict_branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filler word: addi x1, x0, addr[13:2] -- unique per address, never a NOP or control op.
    function automatic logic [31:0] filler(input logic [31:0] a);
        return {a[13:2], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0104: return JAL40;
            32'h0000_0200: return BEQ80;
            32'h0000_0404: return ECALL;
            default:       return filler(a);
        endcase
    endfunction

    // Garbage when no request was made; 0xDEADBEEF even decodes as a JAL.
    always @(posedge clk) begin
        imem_rdata <= imem_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.pred  = pred;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_en"}, {31'd0, imem_en}, 32'd0);
        check({tag, "_instr"}, instruction_IFID_in, NOP);
        check({tag, "_pc"}, PC_IFID_in, 32'd0);
        check({tag, "_pc4"}, PC_plus4_IFID_in, 32'd4);
        check({tag, "_ecall"}, {31'd0, ECALL_IFID_in}, 32'd0);
        check({tag, "_pred"}, {31'd0, predict_branch_taken}, 32'd0);
    endtask

    // Returns just after the posedge following the cycle that consumed the last record.
    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        n_checks++;
        $display("FAIL drain_%s: %0d records still pending, required 0", tag, exp_q.size());
        exp_q.delete();
    endtask

    // Monitor: every cycle the DUT hands an instruction to ID (not stalled, not flushed).
    always @(negedge clk) begin
        if (rst_n && !stall && !redirect_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_extra: got pc=%h instr=%h, required no presentation",
                         PC_IFID_in, instruction_IFID_in);
            end else begin
                exp_t e;
                logic [31:0] p4;
                e  = exp_q.pop_front();
                p4 = e.pc + 32'd4;
                if (PC_IFID_in === e.pc && PC_plus4_IFID_in === p4 &&
                    instruction_IFID_in === e.instr &&
                    ECALL_IFID_in === (e.instr == ECALL) &&
                    predict_branch_taken === e.pred) begin
                    n_pass++;
                end else begin
                    $display("FAIL stream: got pc=%h pc4=%h instr=%h ecall=%b pred=%b, required pc=%h pc4=%h instr=%h ecall=%b pred=%b",
                             PC_IFID_in, PC_plus4_IFID_in, instruction_IFID_in, ECALL_IFID_in,
                             predict_branch_taken, e.pc, p4, e.instr, (e.instr == ECALL), e.pred);
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'd0;
        bp_update_valid = 1'b0;
        bp_update_pc    = 32'd0;
        bp_update_taken = 1'b0;
        #3;
        check_reset_outputs("reset");

        // Boot, sequential fetch, JAL +0x40 at 0x104 with one bubble at 0x108.
        push(32'h0, NOP, 1'b0);
        push(32'h0, NOP, 1'b0);
        push(32'h100, filler(32'h100), 1'b0);
        push(32'h104, JAL40, 1'b1);
        push(32'h108, NOP, 1'b0);
        push(32'h144, filler(32'h144), 1'b0);
        push(32'h148, filler(32'h148), 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("boot_imem_en", {31'd0, imem_en}, 32'd0);
        wait_drain("jal");

        // Redirect to 0x10C, then stall three cycles while it is presented.
        push(32'h14C, NOP, 1'b0);
        push(32'h10C, filler(32'h10C), 1'b0);
        push(32'h110, filler(32'h110), 1'b0);
        push(32'h114, filler(32'h114), 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10C;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(posedge clk);
        #1 stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_imem_en", k), {31'd0, imem_en}, 32'd0);
            check($sformatf("stall%0d_pc", k), PC_IFID_in, 32'h10C);
            check($sformatf("stall%0d_instr", k), instruction_IFID_in, filler(32'h10C));
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        wait_drain("stall");

        // Redirect to 0x403 while stalled: overrides stall, word-aligned to 0x400; ECALL at 0x404.
        push(32'h118, NOP, 1'b0);
        push(32'h400, filler(32'h400), 1'b0);
        push(32'h404, ECALL, 1'b0);
        push(32'h408, filler(32'h408), 1'b0);
        stall = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h403;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        @(negedge clk);
        check("redir_imem_en", {31'd0, imem_en}, 32'd1);
        check("redir_imem_addr", imem_addr, 32'h400);
        wait_drain("redirect");

        // BEQ at 0x200 with counter at weak not-taken: falls through.
        push(32'h40C, NOP, 1'b0);
        push(32'h200, BEQ80, 1'b0);
        push(32'h204, filler(32'h204), 1'b0);
        push(32'h208, filler(32'h208), 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_drain("beq_nt");

        // Two taken updates (01->11), then refetch: predicted taken to 0x280 after one bubble.
        push(32'h20C, NOP, 1'b0);
        push(32'h200, BEQ80, 1'b1);
        push(32'h204, NOP, 1'b0);
        push(32'h280, filler(32'h280), 1'b0);
        push(32'h284, filler(32'h284), 1'b0);
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h200;
        bp_update_valid = 1'b1;
        bp_update_pc    = 32'h200;
        bp_update_taken = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        redirect_valid  = 1'b0;
        bp_update_valid = 1'b0;
        wait_drain("beq_t");

        // PC wrap-around: 0xFFFFFFFC + 4 = 0.
        push(32'h288, NOP, 1'b0);
        push(32'hFFFF_FFFC, filler(32'hFFFF_FFFC), 1'b0);
        push(32'h0, filler(32'h0), 1'b0);
        push(32'h4, filler(32'h4), 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_drain("wrap");

        // Stall on 0x8, then asynchronous reset in the middle of the cycle.
        stall = 1'b1;
        @(negedge clk);
        check("hold_pc", PC_IFID_in, 32'h8);
        check("hold_instr", instruction_IFID_in, filler(32'h8));
        check("hold_imem_en", {31'd0, imem_en}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage that produces the IF→ID pipeline inputs: PC, PC+4, instruction, ECALL flag and branch-prediction bit. It owns the fetch PC and issues requests to a synchronous instruction memory with 1-cycle read latency. It applies static JAL and 2-bit-counter conditional-branch prediction, and accepts redirects and predictor updates from EX.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
BHT_ENTRIES, 64, number of 2-bit counters (power of 2); index = PC[log2(BHT_ENTRIES)+1:2]

Ports:
clk  input  1  clock
rst_n  input  1  async active-low reset
stall  input  1  hazard stall: hold fetch and outputs
redirect_valid  input  1  EX mispredict/jump correction
redirect_pc  input  32  corrected fetch address
bp_update_valid  input  1  resolved conditional branch from EX
bp_update_pc  input  32  PC of resolved branch
bp_update_taken  input  1  actual branch outcome
imem_en  output  1  memory read enable
imem_addr  output  32  memory word address (byte addr, [1:0]=0)
imem_rdata  input  32  data for address presented the previous cycle
PC_IFID_in  output  32  PC of presented instruction
PC_plus4_IFID_in  output  32  PC_IFID_in + 4 (mod 2^32)
instruction_IFID_in  output  32  instruction or NOP_INSTR_HEX (32'h00000013)
ECALL_IFID_in  output  1  instruction == 32'h00000073
predict_branch_taken  output  1  fetch redirected to predicted target

Behaviour:
- State: pc_fetch (32), F1 register {f1_pc, f1_valid}, hold register {hold_instr, hold_pred}, FSM {BOOT, RUN, HOLD}, BHT.
- Reset: pc_fetch=RESET_PC, f1_valid=0, f1_pc=0, FSM=BOOT, all BHT counters=2'b01 (weak not-taken). Outputs during reset: imem_en=0, instruction=NOP, PC_IFID_in=0, PC_plus4=4, ECALL=0, predict=0.
- BOOT: one cycle, imem_en=0, go to RUN.
- RUN, no stall, no redirect: imem_en=1, imem_addr=pc_fetch. Edge: f1_pc<=pc_fetch, f1_valid<=1, pc_fetch<=next_pc.
- Output (RUN): f1_valid=1 → instruction=imem_rdata, PC=f1_pc. f1_valid=0 → instruction=NOP, predict=0, ECALL=0, PC=f1_pc.
- Prediction (combinational on presented valid instruction, RUN only):
  - JAL (opcode 1101111): taken, target = f1_pc + imm_J.
  - B-type (opcode 1100011): taken iff BHT[idx(f1_pc)][1]==1, target = f1_pc + imm_B.
  - Otherwise not taken.
- Taken prediction: next_pc=target, f1_valid<=0 (squash the sequential request already in flight), predict_branch_taken=1 for this instruction.
- Not taken: next_pc = pc_fetch + 4. Net cost: exactly one NOP bubble per predicted-taken branch.
- stall=1, no redirect:
  - RUN→HOLD; capture presented instruction/pred into hold register.
  - imem_en=0; pc_fetch and F1 frozen.
  - Outputs stable every stalled cycle, driven from the hold register in HOLD, independent of imem_rdata.
  - Prediction not re-applied (already taken effect, or not).
- Stall release: HOLD→RUN.
  - Release cycle re-issues pc_fetch; outputs still show the held instruction.
  - Next cycle resumes from F1.
  - No instruction duplicated or dropped.
- redirect_valid=1: highest priority, overrides stall and prediction.
  - pc_fetch <= {redirect_pc[31:2],2'b00}, f1_valid<=0, FSM<=RUN.
  - Following cycle presents NOP; first redirected instruction appears 2 cycles after redirect.
- BHT update: on bp_update_valid, saturating ±1 at idx(bp_update_pc) (inc if taken, sat 11; dec else, sat 00).
- Same-cycle update and lookup at the same index: lookup sees the old value.
- PC arithmetic is 32-bit wrap-around; 32'hFFFF_FFFC+4 = 0.
- Async reset mid-stall or mid-redirect returns to reset values immediately.

Test Plan:
- Reset RESET_PC=0x100, memory of ADDI → cycle 1 BOOT NOP; then PCs 0x100,0x104,0x108 on consecutive cycles, PC_plus4 = PC+4.
- JAL +0x40 at 0x104 → 0x104 shown with predict=1, next cycle NOP (PC 0x108), then 0x144; 0x108 never presented as a valid instruction.
- BEQ at 0x200 with counter reset 01 → predict=0, sequential; after two bp_update taken at 0x200 (→11), refetch of 0x200 gives predict=1 and target fetched after one bubble.
- stall held 3 cycles while instruction 0x10C shown → outputs unchanged for all 3 cycles, imem_en=0; after release 0x110 follows 0x10C exactly once.
- redirect_valid with redirect_pc=0x403 asserted during stall → stall overridden, imem_addr=0x400 next cycle, one NOP, then 0x400 presented.
- instruction 32'h00000073 fetched → ECALL_IFID_in=1 for that cycle only; assert rst_n low mid-stall → all outputs to reset values asynchronously.
